// File: rtl/turn_input_cond.sv
// turn_input_cond: switch synchronizer/debouncer and blink timebase that feed
// the turn-signal sequencer.
// Optional feature macro: TURN_COND_TICK_RESYNC_EN. When it is defined, any
// change of the debounced lever levels restarts the blink phase.
module turn_input_cond #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HALF_PERIOD     = 12500000
) (
  input  logic clock,
  input  logic reset,
  input  logic left_sw,
  input  logic right_sw,
  output logic left,
  output logic right,
  output logic blink_clk,
  output logic step_tick
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int TW = $clog2(HALF_PERIOD) + 1;
  localparam logic [DW-1:0] DCNT_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TCNT_MAX = TW'(HALF_PERIOD - 1);

  // Two-flop synchronizer chains. Only the s2 stage is used downstream.
  logic left_s1_q,  left_s1_d,  left_s2_q,  left_s2_d;
  logic right_s1_q, right_s1_d, right_s2_q, right_s2_d;

  // Debouncer state: stable output level and the disagreement counter.
  logic          left_q,       left_d;
  logic          right_q,      right_d;
  logic [DW-1:0] left_dcnt_q,  left_dcnt_d;
  logic [DW-1:0] right_dcnt_q, right_dcnt_d;

  // Timebase state.
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          blink_q, blink_d;
  logic          tick_q,  tick_d;

  // Synchronizer next state: shift each raw switch through two stages.
  // NOTE: the raw switches are asynchronous, so they only ever reach the
  // first synchronizer stage; everything else looks at s2.
  always_comb begin
    left_s1_d  = left_sw;
    left_s2_d  = left_s1_q;
    right_s1_d = right_sw;
    right_s2_d = right_s1_q;
  end

  // Debouncer next state: flip the output only after DEBOUNCE_CYCLES
  // consecutive disagreeing samples; any agreement restarts the count.
  // NOTE: every signal written here gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    left_d       = left_q;
    left_dcnt_d  = left_dcnt_q;
    right_d      = right_q;
    right_dcnt_d = right_dcnt_q;

    if (left_s2_q == left_q) begin
      left_dcnt_d = '0;
    end else if (left_dcnt_q == DCNT_MAX) begin
      left_d      = left_s2_q;
      left_dcnt_d = '0;
    end else begin
      left_dcnt_d = left_dcnt_q + 1'b1;
    end

    if (right_s2_q == right_q) begin
      right_dcnt_d = '0;
    end else if (right_dcnt_q == DCNT_MAX) begin
      right_d      = right_s2_q;
      right_dcnt_d = '0;
    end else begin
      right_dcnt_d = right_dcnt_q + 1'b1;
    end
  end

  // Timebase next state: toggle blink_clk every HALF_PERIOD cycles and
  // raise step_tick together with each rising blink_clk edge.
  always_comb begin
    tcnt_d  = tcnt_q + 1'b1;
    blink_d = blink_q;
    tick_d  = 1'b0;

    if (tcnt_q == TCNT_MAX) begin
      tcnt_d  = '0;
      blink_d = ~blink_q;
      tick_d  = ~blink_q;
    end

`ifdef TURN_COND_TICK_RESYNC_EN
    // A lever change restarts the phase, so the first step lands exactly
    // HALF_PERIOD cycles later; a tick due on this edge is dropped.
    if ((left_d != left_q) || (right_d != right_q)) begin
      tcnt_d  = '0;
      blink_d = 1'b0;
      tick_d  = 1'b0;
    end
`endif
  end

  // State registers with synchronous active-high reset.
  // NOTE: non-blocking assignments here so every flop samples the values
  // from before the edge, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      left_s1_q    <= 1'b0;
      left_s2_q    <= 1'b0;
      right_s1_q   <= 1'b0;
      right_s2_q   <= 1'b0;
      left_q       <= 1'b0;
      right_q      <= 1'b0;
      left_dcnt_q  <= '0;
      right_dcnt_q <= '0;
      tcnt_q       <= '0;
      blink_q      <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      left_s1_q    <= left_s1_d;
      left_s2_q    <= left_s2_d;
      right_s1_q   <= right_s1_d;
      right_s2_q   <= right_s2_d;
      left_q       <= left_d;
      right_q      <= right_d;
      left_dcnt_q  <= left_dcnt_d;
      right_dcnt_q <= right_dcnt_d;
      tcnt_q       <= tcnt_d;
      blink_q      <= blink_d;
      tick_q       <= tick_d;
    end
  end

  assign left      = left_q;
  assign right     = right_q;
  assign blink_clk = blink_q;
  assign step_tick = tick_q;

endmodule

// File: tb/tb_turn_input_cond.sv
// Directed testbench for turn_input_cond. The main instance runs with
// DEBOUNCE_CYCLES=4, HALF_PERIOD=5; a second instance covers the minimum
// settings (1, 1). Expected values are closed-form functions of the edge
// count n since the last reset edge (edge 0).
module tb_turn_input_cond;

  localparam int D   = 4;
  localparam int HP  = 5;
  localparam int INF = 1 << 30;

  logic clock = 1'b0;
  logic reset;
  logic left_sw, right_sw;
  logic left, right, blink_clk, step_tick;
  logic left1, right1, blink1, tick1;

  turn_input_cond #(.DEBOUNCE_CYCLES(D), .HALF_PERIOD(HP)) u_dut (
    .clock     (clock),
    .reset     (reset),
    .left_sw   (left_sw),
    .right_sw  (right_sw),
    .left      (left),
    .right     (right),
    .blink_clk (blink_clk),
    .step_tick (step_tick)
  );

  turn_input_cond #(.DEBOUNCE_CYCLES(1), .HALF_PERIOD(1)) u_dut_min (
    .clock     (clock),
    .reset     (reset),
    .left_sw   (left_sw),
    .right_sw  (right_sw),
    .left      (left1),
    .right     (right1),
    .blink_clk (blink1),
    .step_tick (tick1)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int n;                    // edges since the last reset edge
  int base;                 // edge at which the blink phase last restarted
  int left_on, right_on;    // edge at which left/right are expected to rise
  int left1_on;             // same for the minimum-setting instance
  bit prev_el, prev_er;
  bit chk1_tb, chk1_lv;     // enable checks on the minimum-setting instance

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got=%0h expected=%0h", tag, n, got, exp);
    end
  endtask

  task automatic step_edge();
    @(posedge clock);
    #1;
    n++;
  endtask

  task automatic do_reset(input logic l, input logic r);
    left_sw  = l;
    right_sw = r;
    reset    = 1'b1;
    step_edge();
    reset    = 1'b0;
    n        = 0;
    base     = 0;
    left_on  = INF;
    right_on = INF;
    left1_on = INF;
    prev_el  = 1'b0;
    prev_er  = 1'b0;
    check("rst_left",      left,      1'b0);
    check("rst_right",     right,     1'b0);
    check("rst_blink_clk", blink_clk, 1'b0);
    check("rst_step_tick", step_tick, 1'b0);
  endtask

  task automatic run(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      bit el;
      bit er;
      step_edge();
      el = (n >= left_on);
      er = (n >= right_on);
`ifdef TURN_COND_TICK_RESYNC_EN
      if ((el != prev_el) || (er != prev_er)) base = n;
`endif
      prev_el = el;
      prev_er = er;
      check("left",      left,      el);
      check("right",     right,     er);
      check("blink_clk", blink_clk, (((n - base) / HP) % 2) == 1);
      check("step_tick", step_tick, ((n - base) % (2 * HP)) == HP);
      if (chk1_tb) begin
        check("blink_clk_min", blink1, (n % 2) == 1);
        check("step_tick_min", tick1,  (n % 2) == 1);
      end
      if (chk1_lv) begin
        check("left_min",  left1,  n >= left1_on);
        check("right_min", right1, 1'b0);
      end
    end
  endtask

  initial begin
    left_sw  = 1'b0;
    right_sw = 1'b0;
    reset    = 1'b1;
    n        = 0;
    chk1_tb  = 1'b0;
    chk1_lv  = 1'b0;
    step_edge();

    // Idle after reset: levels low, blink rises at 5,15,25,35, falls at
    // 10,20,30; the minimum instance toggles every cycle.
    do_reset(1'b0, 1'b0);
    chk1_tb = 1'b1;
    chk1_lv = 1'b1;
    run(40);
    chk1_tb = 1'b0;

    // Left lever steady from before edge 41: left rises at 46 (41+1+D),
    // the minimum instance at 43; right stays low.
    left_sw  = 1'b1;
    left_on  = 41 + 1 + D;
    left1_on = 41 + 2;
    run(12);
    chk1_lv = 1'b0;

    // Bounce 1,0,1,1,0 before edges 1..5, then steady 1 from before
    // edge 6: exactly one rise, at edge 11.
    do_reset(1'b0, 1'b0);
    left_on = 6 + 1 + D;
    left_sw = 1'b1; run(1);
    left_sw = 1'b0; run(1);
    left_sw = 1'b1; run(1);
    left_sw = 1'b1; run(1);
    left_sw = 1'b0; run(1);
    left_sw = 1'b1; run(12);

    // Both levers rise together before edge 3: both outputs at edge 8.
    do_reset(1'b0, 1'b0);
    run(2);
    left_sw  = 1'b1;
    right_sw = 1'b1;
    left_on  = 3 + 1 + D;
    right_on = 3 + 1 + D;
    run(15);

    // Reset mid-debounce (dcnt=3) and mid-count (tcnt=4) after edge 14:
    // everything clears, then the held lever shows up D+2 edges later and
    // the timebase starts over.
    do_reset(1'b0, 1'b0);
    run(9);
    left_sw = 1'b1;
    left_on = 10 + 1 + D;
    run(4);
    do_reset(1'b1, 1'b0);
    left_on = D + 2;
    run(14);

    // Right lever rises at edge 12 while blink is mid-phase: default build
    // keeps the free-running phase; the resync build restarts it at 12.
    do_reset(1'b0, 1'b0);
    run(6);
    right_sw = 1'b1;
    right_on = 7 + 1 + D;
    run(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
